// File: rtl/fp_pkg.sv
// Shared FP32/BF16 field layout, value classes and flag positions for the narrowing converters.
package fp_pkg;

  localparam int FP32_W        = 32;
  localparam int BF16_W        = 16;
  localparam int EXP_W         = 8;
  localparam int FP32_FRAC_W   = 23;
  localparam int BF16_FRAC_W   = 7;
  localparam int FP32_SIGN_BIT = 31;
  localparam int FP32_EXP_LSB  = 23;
  localparam int BF16_EXP_LSB  = 7;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam int BF16_QNAN_BIT = 6;

  localparam int FLAG_W        = 3;
  localparam int FLAG_INEXACT  = 0;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_NAN      = 2;

  typedef enum logic [4:0] {
    CLS_ZERO = 5'b00001,
    CLS_SUB  = 5'b00010,
    CLS_NORM = 5'b00100,
    CLS_INF  = 5'b01000,
    CLS_NAN  = 5'b10000
  } fp_class_e;

  function automatic fp_class_e classify(input logic [EXP_W-1:0] exp, input logic frac_nz);
    if (exp == '0)      return frac_nz ? CLS_SUB : CLS_ZERO;
    if (exp == EXP_MAX) return frac_nz ? CLS_NAN : CLS_INF;
    return CLS_NORM;
  endfunction

endpackage

// File: rtl/bfp16_round_pack.sv
// Combinational round-to-nearest-even and special-case packing of a pre-split FP32 word into BF16.
module bfp16_round_pack
  import fp_pkg::*;
#(
  parameter int FLUSH_DENORM = 0
) (
  input  logic              sign,
  input  logic [15:0]       upper,
  input  logic              guard,
  input  logic              sticky,
  input  logic              lsb,
  input  logic              frac_nz,
  input  fp_class_e         cls,
  output logic [15:0]       res,
  output logic [FLAG_W-1:0] flags
);

  logic        round_up;
  logic [15:0] sum;

  assign round_up = guard & (sticky | lsb);
  // Sign sits in bit 15; a fraction carry ripples into the exponent field and
  // can never reach the sign because the exponent of a finite input is below EXP_MAX.
  assign sum = upper + {15'b0, round_up};

  always_comb begin
    res   = '0;
    flags = '0;
    case (cls)
      CLS_ZERO: res = {sign, 15'h0000};
      CLS_INF:  res = {sign, EXP_MAX, 7'h00};
      CLS_NAN: begin
        res = {sign, EXP_MAX, 1'b1, upper[BF16_QNAN_BIT-1:0]};
        flags[FLAG_NAN] = 1'b1;
      end
      CLS_SUB, CLS_NORM: begin
        if ((cls == CLS_SUB) && (FLUSH_DENORM != 0)) begin
          res = {sign, 15'h0000};
          flags[FLAG_INEXACT] = frac_nz;
        end else begin
          flags[FLAG_INEXACT] = guard | sticky;
          if (sum[14:BF16_EXP_LSB] == EXP_MAX) begin
            res = {sign, EXP_MAX, 7'h00};
            flags[FLAG_OVERFLOW] = 1'b1;
            flags[FLAG_INEXACT]  = 1'b1;
          end else begin
            res = sum;
          end
        end
      end
      default: begin
        res   = '0;
        flags = '0;
      end
    endcase
  end

endmodule

// File: rtl/fp32_to_bfp16_conv.sv
// Two-stage elastic FP32 -> BF16 converter (classify, then round/pack) with RNE rounding.
// Optional statistics counters are enabled by defining FP32_TO_BFP16_CONV_STATS_EN.
module fp32_to_bfp16_conv
  import fp_pkg::*;
#(
  parameter int FLUSH_DENORM = 0
`ifdef FP32_TO_BFP16_CONV_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
`ifdef FP32_TO_BFP16_CONV_STATS_EN
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  cnt_inexact,
  output logic [CNT_W-1:0]  cnt_overflow,
  output logic [CNT_W-1:0]  cnt_nan,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic [FLAG_W-1:0] out_flags
);

  // valid/ready: a word moves on a rising edge where valid & ready are both high;
  // the sender holds the word stable while valid & !ready.
  logic        adv1, adv2;
  logic        s1_valid, s2_valid;
  logic        s1_sign, s1_guard, s1_sticky, s1_lsb, s1_frac_nz;
  logic [15:0] s1_upper;
  fp_class_e   s1_class;

  logic [15:0]       rp_res;
  logic [FLAG_W-1:0] rp_flags;

  assign adv2      = !s2_valid | out_ready;
  assign adv1      = !s1_valid | adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_sign    <= 1'b0;
      s1_upper   <= '0;
      s1_guard   <= 1'b0;
      s1_sticky  <= 1'b0;
      s1_lsb     <= 1'b0;
      s1_frac_nz <= 1'b0;
      s1_class   <= CLS_ZERO;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign    <= in_data[FP32_SIGN_BIT];
        s1_upper   <= in_data[31:16];
        s1_guard   <= in_data[15];
        s1_sticky  <= |in_data[14:0];
        s1_lsb     <= in_data[16];
        s1_frac_nz <= |in_data[FP32_FRAC_W-1:0];
        s1_class   <= classify(in_data[30:FP32_EXP_LSB], |in_data[FP32_FRAC_W-1:0]);
      end
    end
  end

  bfp16_round_pack #(
    .FLUSH_DENORM(FLUSH_DENORM)
  ) u_round_pack (
    .sign    (s1_sign),
    .upper   (s1_upper),
    .guard   (s1_guard),
    .sticky  (s1_sticky),
    .lsb     (s1_lsb),
    .frac_nz (s1_frac_nz),
    .cls     (s1_class),
    .res     (rp_res),
    .flags   (rp_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= rp_res;
        out_flags <= rp_flags;
      end
    end
  end

`ifdef FP32_TO_BFP16_CONV_STATS_EN
  logic             out_xfer;
  logic [CNT_W-1:0] cnt_one;

  assign out_xfer = out_valid & out_ready;
  assign cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_inexact  <= '0;
      cnt_overflow <= '0;
      cnt_nan      <= '0;
    end else if (stat_clr) begin
      cnt_inexact  <= '0;
      cnt_overflow <= '0;
      cnt_nan      <= '0;
    end else if (out_xfer) begin
      if (out_flags[FLAG_INEXACT] && (cnt_inexact != '1))
        cnt_inexact <= cnt_inexact + cnt_one;
      if (out_flags[FLAG_OVERFLOW] && (cnt_overflow != '1))
        cnt_overflow <= cnt_overflow + cnt_one;
      if (out_flags[FLAG_NAN] && (cnt_nan != '1))
        cnt_nan <= cnt_nan + cnt_one;
    end
  end
`endif

endmodule

// File: tb/tb_fp32_to_bfp16_conv.sv
// Directed bench for fp32_to_bfp16_conv: two instances (subnormals rounded / flushed) share stimulus.
module tb_fp32_to_bfp16_conv;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready, in_ready_fl;
  logic        out_valid, out_valid_fl;
  logic [15:0] out_data, out_data_fl;
  logic [2:0]  out_flags, out_flags_fl;

  int n_vec = 0;
  int n_err = 0;

  logic [18:0] exp_q[$];
  logic [18:0] exp_fl_q[$];

`ifdef FP32_TO_BFP16_CONV_STATS_EN
  logic        stat_clr;
  logic [15:0] cnt_inexact, cnt_overflow, cnt_nan;
  logic [15:0] cnt_inexact_fl, cnt_overflow_fl, cnt_nan_fl;
  initial stat_clr = 1'b0;
`endif

  fp32_to_bfp16_conv #(.FLUSH_DENORM(0)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef FP32_TO_BFP16_CONV_STATS_EN
    .stat_clr     (stat_clr),
    .cnt_inexact  (cnt_inexact),
    .cnt_overflow (cnt_overflow),
    .cnt_nan      (cnt_nan),
`endif
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_flags    (out_flags)
  );

  fp32_to_bfp16_conv #(.FLUSH_DENORM(1)) dut_fl (
    .clk          (clk),
    .rst          (rst),
`ifdef FP32_TO_BFP16_CONV_STATS_EN
    .stat_clr     (stat_clr),
    .cnt_inexact  (cnt_inexact_fl),
    .cnt_overflow (cnt_overflow_fl),
    .cnt_nan      (cnt_nan_fl),
`endif
    .in_valid     (in_valid),
    .in_ready     (in_ready_fl),
    .in_data      (in_data),
    .out_valid    (out_valid_fl),
    .out_ready    (out_ready),
    .out_data     (out_data_fl),
    .out_flags    (out_flags_fl)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // scoreboard: every output transfer must match the head of its expected queue
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("dut_stray_out", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        chk("dut_out_word", {13'b0, out_flags, out_data}, {13'b0, exp_q[0]});
        void'(exp_q.pop_front());
      end
    end
    if (!rst && out_valid_fl && out_ready) begin
      chk("fl_stray_out", 32'(exp_fl_q.size() > 0), 32'd1);
      if (exp_fl_q.size() > 0) begin
        chk("fl_out_word", {13'b0, out_flags_fl, out_data_fl}, {13'b0, exp_fl_q[0]});
        void'(exp_fl_q.pop_front());
      end
    end
  end

  // driver: present one word, return at #1 after the edge that accepted it
  task automatic send(input logic [31:0] w, input logic [18:0] e, input logic [18:0] ef);
    bit acc;
    int cyc;
    acc = 1'b0;
    cyc = 0;
    in_valid = 1'b1;
    in_data  = w;
    exp_q.push_back(e);
    exp_fl_q.push_back(ef);
    while (!acc && cyc < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("send_accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || exp_fl_q.size() != 0) && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("drain_done", 32'(exp_q.size() + exp_fl_q.size()), 32'd0);
  endtask

  logic [31:0] bp_in  [8];
  logic [18:0] bp_exp [8];
  logic [18:0] held;

  initial begin
    bp_in[0] = 32'h40000000; bp_exp[0] = {3'b000, 16'h4000};
    bp_in[1] = 32'h40008000; bp_exp[1] = {3'b001, 16'h4000};
    bp_in[2] = 32'h40018000; bp_exp[2] = {3'b001, 16'h4002};
    bp_in[3] = 32'hC0A00001; bp_exp[3] = {3'b001, 16'hC0A0};
    bp_in[4] = 32'h42C80000; bp_exp[4] = {3'b000, 16'h42C8};
    bp_in[5] = 32'h3DCCCCCD; bp_exp[5] = {3'b001, 16'h3DCD};
    bp_in[6] = 32'hBF000000; bp_exp[6] = {3'b000, 16'hBF00};
    bp_in[7] = 32'h447A0000; bp_exp[7] = {3'b000, 16'h447A};

    // reset state
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", {16'b0, out_data}, 32'h0000);
    chk("rst_out_flags", {29'b0, out_flags}, 32'd0);
    chk("rst_fl_out_valid", {31'b0, out_valid_fl}, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

    // first word latency: accepted at edge A, visible after edge A+1
    send(32'h3F800000, {3'b000, 16'h3F80}, {3'b000, 16'h3F80});
    chk("lat_not_early", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", {31'b0, out_valid}, 32'd1);
    chk("lat_data", {16'b0, out_data}, 32'h3F80);
    drain();

    // rounding, overflow, specials, subnormals at full throughput
    send(32'h3F808000, {3'b001, 16'h3F80}, {3'b001, 16'h3F80});
    send(32'h3F818000, {3'b001, 16'h3F82}, {3'b001, 16'h3F82});
    send(32'h3F80C000, {3'b001, 16'h3F81}, {3'b001, 16'h3F81});
    send(32'h3F7FFF80, {3'b001, 16'h3F80}, {3'b001, 16'h3F80});
    send(32'h7F7FFFFF, {3'b011, 16'h7F80}, {3'b011, 16'h7F80});
    send(32'hFF800000, {3'b000, 16'hFF80}, {3'b000, 16'hFF80});
    send(32'h80000000, {3'b000, 16'h8000}, {3'b000, 16'h8000});
    send(32'h7F800001, {3'b100, 16'h7FC0}, {3'b100, 16'h7FC0});
    send(32'h7FC12345, {3'b100, 16'h7FC1}, {3'b100, 16'h7FC1});
    send(32'h00400000, {3'b000, 16'h0040}, {3'b001, 16'h0000});
    send(32'h007FFFFF, {3'b001, 16'h0080}, {3'b001, 16'h0000});
    send(32'h80400000, {3'b000, 16'h8040}, {3'b001, 16'h8000});
    drain();

    // backpressure: out_ready low for 5 cycles while 8 words stream in
    fork
      begin
        for (int i = 0; i < 8; i++) send(bp_in[i], bp_exp[i], bp_exp[i]);
      end
      begin
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        chk("bp_head_word", {13'b0, out_flags, out_data}, {13'b0, bp_exp[0]});
        held = {out_flags, out_data};
        repeat (2) @(posedge clk);
        #1;
        chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_hold_word", {13'b0, out_flags, out_data}, {13'b0, held});
        out_ready = 1'b1;
      end
    join
    drain();

    // async reset with two words in flight
    out_ready = 1'b0;
    send(32'h3F800000, {3'b000, 16'h3F80}, {3'b000, 16'h3F80});
    send(32'h40000000, {3'b000, 16'h4000}, {3'b000, 16'h4000});
    chk("mid_valid_before_rst", {31'b0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_fl_out_valid", {31'b0, out_valid_fl}, 32'd0);
    chk("mid_rst_out_data", {16'b0, out_data}, 32'h0000);
    exp_q.delete();
    exp_fl_q.delete();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_no_stale", {31'b0, out_valid}, 32'd0);
    send(32'h40490FDB, {3'b001, 16'h4049}, {3'b001, 16'h4049});
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
